// File: rtl/cc_fill_line_assembler.sv
// ----------------------------------------------------------------------------
// cc_fill_line_assembler
//
// Receiving end of the memory R channel on a cache miss. Takes one miss fill
// request at a time, collects the BEATS beats of a wrap burst (critical word
// first) into a single line register, then presents the line with its latched
// index/tag to the data/tag SRAM fill path.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   fill_req_valid_i      miss fill request valid
//   fill_req_ready_o      request accepted (high only while idle)
//   fill_req_index_i      set index of the miss
//   fill_req_tag_i        tag of the miss
//   fill_req_ofs_i        word offset of the critical (first) beat
//   mem_rdata_i           R beat data
//   mem_rlast_i           R last-beat marker
//   mem_rvalid_i          R beat valid
//   mem_rready_o          R ready (high only while collecting)
//   line_valid_o          assembled line valid
//   line_ready_i          fill path accepts the line
//   line_data_o           line; word w at [w*DATA_WIDTH +: DATA_WIDTH]
//   line_index_o          latched index
//   line_tag_o            latched tag
//   proto_err_o           one-cycle pulse: rlast seen on the wrong beat
// ----------------------------------------------------------------------------
module cc_fill_line_assembler #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BEATS       = 8,   // power of two, at least 2
    parameter int unsigned INDEX_WIDTH = 9,
    parameter int unsigned TAG_WIDTH   = 17,
    localparam int unsigned LINE_W     = DATA_WIDTH * BEATS,
    localparam int unsigned OFS_W      = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   fill_req_valid_i,
    output logic                   fill_req_ready_o,
    input  logic [INDEX_WIDTH-1:0] fill_req_index_i,
    input  logic [TAG_WIDTH-1:0]   fill_req_tag_i,
    input  logic [OFS_W-1:0]       fill_req_ofs_i,

    input  logic [DATA_WIDTH-1:0]  mem_rdata_i,
    input  logic                   mem_rlast_i,
    input  logic                   mem_rvalid_i,
    output logic                   mem_rready_o,

    output logic                   line_valid_o,
    input  logic                   line_ready_i,
    output logic [LINE_W-1:0]      line_data_o,
    output logic [INDEX_WIDTH-1:0] line_index_o,
    output logic [TAG_WIDTH-1:0]   line_tag_o,

    output logic                   proto_err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite
    } state_e;

    localparam logic [OFS_W-1:0] LastCnt = OFS_W'(BEATS - 1);

    state_e                 state_q, state_d;
    logic [OFS_W-1:0]       ptr_q, ptr_d;
    logic [OFS_W-1:0]       cnt_q, cnt_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   err_q, err_d;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        index_d = index_q;
        tag_d   = tag_q;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fill_req_valid_i) begin
                    index_d = fill_req_index_i;
                    tag_d   = fill_req_tag_i;
                    ptr_d   = fill_req_ofs_i;
                    cnt_d   = '0;
                    state_d = StCollect;
                end
            end

            StCollect: begin
                if (mem_rvalid_i) begin
                    for (int w = 0; w < int'(BEATS); w++) begin
                        if (ptr_q == OFS_W'(w)) begin
                            line_d[w*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
                        end
                    end
                    // Wrap burst: pointer rolls over naturally at BEATS.
                    ptr_d = ptr_q + OFS_W'(1);
                    cnt_d = cnt_q + OFS_W'(1);
                    // The burst length is fixed; rlast is only checked, never
                    // used to terminate collection.
                    if (cnt_q == LastCnt) begin
                        state_d = StWrite;
                        err_d   = ~mem_rlast_i;
                    end else begin
                        err_d   = mem_rlast_i;
                    end
                end
            end

            StWrite: begin
                if (line_ready_i) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            index_q <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            index_q <= index_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: handshakes decoded from state, everything else registered
    // ------------------------------------------------------------------------
    assign fill_req_ready_o = (state_q == StIdle);
    assign mem_rready_o     = (state_q == StCollect);
    assign line_valid_o     = (state_q == StWrite);
    assign line_data_o      = line_q;
    assign line_index_o     = index_q;
    assign line_tag_o       = tag_q;
    assign proto_err_o      = err_q;

endmodule

// File: tb/tb_cc_fill_line_assembler.sv
// ----------------------------------------------------------------------------
// tb_cc_fill_line_assembler
//
// Self-checking bench: directed fills followed by randomized fills with beat
// gaps, write back-pressure and protocol errors, checked against a line model
// built from the wrap-burst rule word[(ofs + i) mod BEATS] = beat[i].
// ----------------------------------------------------------------------------
module tb_cc_fill_line_assembler;

    localparam int unsigned DW     = 64;
    localparam int unsigned BEATS  = 8;
    localparam int unsigned IW     = 9;
    localparam int unsigned TW     = 17;
    localparam int unsigned LW     = DW * BEATS;
    localparam int unsigned OW     = $clog2(BEATS);

    logic          clk;
    logic          rst;
    logic          fill_req_valid_i;
    logic          fill_req_ready_o;
    logic [IW-1:0] fill_req_index_i;
    logic [TW-1:0] fill_req_tag_i;
    logic [OW-1:0] fill_req_ofs_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_rlast_i;
    logic          mem_rvalid_i;
    logic          mem_rready_o;
    logic          line_valid_o;
    logic          line_ready_i;
    logic [LW-1:0] line_data_o;
    logic [IW-1:0] line_index_o;
    logic [TW-1:0] line_tag_o;
    logic          proto_err_o;

    cc_fill_line_assembler #(
        .DATA_WIDTH  (DW),
        .BEATS       (BEATS),
        .INDEX_WIDTH (IW),
        .TAG_WIDTH   (TW)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .fill_req_valid_i (fill_req_valid_i),
        .fill_req_ready_o (fill_req_ready_o),
        .fill_req_index_i (fill_req_index_i),
        .fill_req_tag_i   (fill_req_tag_i),
        .fill_req_ofs_i   (fill_req_ofs_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_rlast_i      (mem_rlast_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rready_o     (mem_rready_o),
        .line_valid_o     (line_valid_o),
        .line_ready_i     (line_ready_i),
        .line_data_o      (line_data_o),
        .line_index_o     (line_index_o),
        .line_tag_o       (line_tag_o),
        .proto_err_o      (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [DW-1:0] beat_data [BEATS];
    logic          beat_last [BEATS];

    task automatic check_val(input string tag, input logic [LW-1:0] got,
                             input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_proper_last();
        for (int i = 0; i < int'(BEATS); i++) beat_last[i] = (i == int'(BEATS) - 1);
    endtask

    // One complete fill: request, collect (with optional gaps), write with
    // `hold` cycles of back-pressure. `junk` keeps a different request
    // asserted while the fill is busy; it must not be consumed.
    task automatic do_fill(input int ofs, input int hold, input int gap_pct, input bit junk);
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        logic [LW-1:0] exp_line;
        int            exp_errs;
        int            seen_errs;
        int            guard;
        int            i;
        bit            acc;
        bit            rv;
        bit            hs;
        bit            exp_err;

        idx = IW'($urandom);
        tg  = TW'($urandom);
        exp_line = '0;
        exp_errs = 0;
        for (int b = 0; b < int'(BEATS); b++) begin
            exp_line[((ofs + b) % int'(BEATS)) * int'(DW) +: DW] = beat_data[b];
            if (b == int'(BEATS) - 1) exp_errs += beat_last[b] ? 0 : 1;
            else                      exp_errs += beat_last[b] ? 1 : 0;
        end

        fill_req_valid_i = 1'b1;
        fill_req_index_i = idx;
        fill_req_tag_i   = tg;
        fill_req_ofs_i   = OW'(ofs);
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            acc = fill_req_ready_o;
            step();
            guard++;
        end
        if (!acc) check_val("req_accept_timeout", 0, 1);

        if (junk) begin
            fill_req_index_i = ~idx;
            fill_req_tag_i   = ~tg;
            fill_req_ofs_i   = OW'(ofs + 3);
        end else begin
            fill_req_valid_i = 1'b0;
        end
        check_val("rready_in_collect", LW'(mem_rready_o), 1);
        check_val("req_ready_in_collect", LW'(fill_req_ready_o), 0);

        i         = 0;
        guard     = 0;
        seen_errs = 0;
        while (i < int'(BEATS) && guard < 400) begin
            rv = ($urandom_range(99) >= gap_pct);
            mem_rvalid_i = rv;
            mem_rdata_i  = rv ? beat_data[i] : DW'($urandom);
            mem_rlast_i  = rv ? beat_last[i] : 1'($urandom);
            hs      = rv && mem_rready_o;
            exp_err = hs && ((i == int'(BEATS) - 1) ? !beat_last[i] : beat_last[i]);
            if (hs) i++;
            step();
            guard++;
            check_val("proto_err", LW'(proto_err_o), LW'(exp_err));
            check_val("line_valid_timing", LW'(line_valid_o), LW'(i == int'(BEATS)));
            if (proto_err_o) seen_errs++;
        end
        if (i < int'(BEATS)) check_val("beat_timeout", LW'(i), LW'(BEATS));

        // Beats offered during the write phase must be ignored.
        mem_rvalid_i     = 1'b1;
        mem_rdata_i      = '1;
        mem_rlast_i      = 1'b0;
        fill_req_valid_i = 1'b0;

        check_val("line_data", line_data_o, exp_line);
        check_val("line_index", LW'(line_index_o), LW'(idx));
        check_val("line_tag", LW'(line_tag_o), LW'(tg));
        check_val("err_count", LW'(seen_errs), LW'(exp_errs));

        line_ready_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            step();
            check_val("hold_line_valid", LW'(line_valid_o), 1);
            check_val("hold_line_data", line_data_o, exp_line);
            check_val("hold_rready", LW'(mem_rready_o), 0);
            check_val("hold_req_ready", LW'(fill_req_ready_o), 0);
            check_val("hold_proto_err", LW'(proto_err_o), 0);
        end
        line_ready_i = 1'b1;
        step();
        line_ready_i = 1'b0;
        mem_rvalid_i = 1'b0;
        check_val("post_write_line_valid", LW'(line_valid_o), 0);
        check_val("post_write_req_ready", LW'(fill_req_ready_o), 1);
        check_val("post_write_proto_err", LW'(proto_err_o), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst              = 1'b1;
        fill_req_valid_i = 1'b0;
        fill_req_index_i = '0;
        fill_req_tag_i   = '0;
        fill_req_ofs_i   = '0;
        mem_rdata_i      = '0;
        mem_rlast_i      = 1'b0;
        mem_rvalid_i     = 1'b0;
        line_ready_i     = 1'b0;
        step();
        step();
        check_val("rst_req_ready", LW'(fill_req_ready_o), 1);
        check_val("rst_rready", LW'(mem_rready_o), 0);
        check_val("rst_line_valid", LW'(line_valid_o), 0);
        check_val("rst_proto_err", LW'(proto_err_o), 0);
        check_val("rst_line_data", line_data_o, 0);
        check_val("rst_line_index", LW'(line_index_o), 0);
        check_val("rst_line_tag", LW'(line_tag_o), 0);
        rst = 1'b0;
        step();

        // ofs=0, beats 0..7 back-to-back
        for (int b = 0; b < int'(BEATS); b++) beat_data[b] = DW'(b);
        set_proper_last();
        do_fill(0, 0, 0, 1'b0);

        // ofs=5, beats A0..A7: wraps 7->0
        for (int b = 0; b < int'(BEATS); b++) beat_data[b] = DW'(8'hA0 + b);
        do_fill(5, 0, 0, 1'b0);

        // Write back-pressure for 4 cycles
        for (int b = 0; b < int'(BEATS); b++) beat_data[b] = {$urandom, $urandom};
        do_fill(3, 4, 0, 1'b0);

        // rlast on 3rd beat, none on 8th: two error pulses, still 8 beats
        for (int b = 0; b < int'(BEATS); b++) beat_last[b] = (b == 2);
        do_fill(1, 1, 0, 1'b1);
        set_proper_last();

        // Reset mid-burst after 4 beats
        fill_req_valid_i = 1'b1;
        fill_req_ofs_i   = OW'(6);
        fill_req_index_i = IW'(9'h1AB);
        fill_req_tag_i   = TW'(17'h1CAFE);
        step();
        fill_req_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = {$urandom, $urandom};
            mem_rlast_i  = 1'b0;
            step();
        end
        mem_rvalid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("midrst_rready", LW'(mem_rready_o), 0);
        check_val("midrst_line_valid", LW'(line_valid_o), 0);
        check_val("midrst_req_ready", LW'(fill_req_ready_o), 1);
        check_val("midrst_line_data", line_data_o, 0);
        for (int b = 0; b < int'(BEATS); b++) beat_data[b] = {$urandom, $urandom};
        do_fill(2, 0, 0, 1'b0);

        // Randomized fills: gaps, back-pressure, occasional bad rlast
        for (int f = 0; f < 100; f++) begin
            for (int b = 0; b < int'(BEATS); b++) beat_data[b] = {$urandom, $urandom};
            if ($urandom_range(9) == 0) begin
                for (int b = 0; b < int'(BEATS); b++) beat_last[b] = 1'($urandom);
            end else begin
                set_proper_last();
            end
            do_fill(int'($urandom_range(BEATS - 1)), int'($urandom_range(3)), 50,
                    1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
